conv_sequencer: RTL

CONV_SEQUENCER -- requirements
Module: conv_sequencer

---
 rtl/npu_pkg.sv | 15 +
 rtl/conv_pos_counter.sv | 48 ++++
 rtl/conv_sequencer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/npu_pkg.sv
// rtl/npu_pkg.sv - shared FSM state encoding and width defaults for the convolution sequencer
package npu_pkg;

    localparam int DATA_WIDTH_DEFAULT = 8;
    localparam int ADDR_WIDTH_DEFAULT = 6;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        EMIT,
        ERROR
    } seq_state_t;

endpackage

// File: rtl/conv_pos_counter.sv
// rtl/conv_pos_counter.sv - raster walker over valid kernel window positions (row, col, output index)
module conv_pos_counter
    import npu_pkg::*;
#(
    parameter int KERNEL_SIZE = 3,
    parameter int IMG_W       = 6,
    parameter int IMG_H       = 6,
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEFAULT
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  clear,
    input  logic                  advance,
    output logic [ADDR_WIDTH-1:0] row,
    output logic [ADDR_WIDTH-1:0] col,
    output logic [ADDR_WIDTH-1:0] out_idx,
    output logic                  last
);

    localparam logic [ADDR_WIDTH-1:0] COL_MAX = ADDR_WIDTH'(IMG_W - KERNEL_SIZE);
    localparam logic [ADDR_WIDTH-1:0] ROW_MAX = ADDR_WIDTH'(IMG_H - KERNEL_SIZE);

    logic wrap;

    assign wrap = (col == COL_MAX);
    assign last = wrap && (row == ROW_MAX);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            row     <= '0;
            col     <= '0;
            out_idx <= '0;
        end else if (clear) begin
            row     <= '0;
            col     <= '0;
            out_idx <= '0;
        end else if (advance) begin
            out_idx <= out_idx + ADDR_WIDTH'(1);
            if (wrap) begin
                col <= '0;
                row <= row + ADDR_WIDTH'(1);
            end else begin
                col <= col + ADDR_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/conv_sequencer.sv
// rtl/conv_sequencer.sv - steps a convolution engine across a feature map and streams out its results
module conv_sequencer
    import npu_pkg::*;
#(
    parameter int KERNEL_SIZE = 3,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEFAULT,
    parameter int IMG_W       = 6,
    parameter int IMG_H       = 6,
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEFAULT,
    parameter int TIMEOUT     = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_abort,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic                  o_eng_start,
    output logic [ADDR_WIDTH-1:0] o_eng_base_addr,
    output logic                  o_eng_kernel_reload,
    input  logic                  i_eng_done,
    input  logic [DATA_WIDTH-1:0] i_eng_result,
    output logic                  o_res_valid,
    input  logic                  i_res_ready,
    output logic [DATA_WIDTH-1:0] o_res_data,
    output logic [ADDR_WIDTH-1:0] o_res_addr
);

    localparam int TW = $clog2(TIMEOUT + 1);

    generate
        if (IMG_W * IMG_H > 2 ** ADDR_WIDTH) begin : g_bad_map_size
            $error("conv_sequencer: IMG_W*IMG_H exceeds the ADDR_WIDTH address space");
        end
    endgenerate

    seq_state_t            state;
    seq_state_t            state_next;
    logic [TW-1:0]         wait_cnt;
    logic                  timed_out;
    logic                  pos_clear;
    logic                  pos_advance;
    logic                  last;
    logic [ADDR_WIDTH-1:0] row;
    logic [ADDR_WIDTH-1:0] col;
    logic [ADDR_WIDTH-1:0] out_idx;

    assign timed_out   = (wait_cnt == TW'(TIMEOUT - 1));
    assign pos_clear   = ((state == IDLE) || (state == ERROR)) && i_start;
    assign pos_advance = (state == EMIT) && i_res_ready && !i_abort && !last;

    conv_pos_counter #(
        .KERNEL_SIZE (KERNEL_SIZE),
        .IMG_W       (IMG_W),
        .IMG_H       (IMG_H),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_pos (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .clear   (pos_clear),
        .advance (pos_advance),
        .row     (row),
        .col     (col),
        .out_idx (out_idx),
        .last    (last)
    );

    assign o_eng_base_addr = row * ADDR_WIDTH'(IMG_W) + col;
    assign o_res_addr      = out_idx;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Abort outranks engine completion and the result handshake.
    always_comb begin
        state_next          = state;
        o_busy              = 1'b0;
        o_eng_start         = 1'b0;
        o_eng_kernel_reload = 1'b0;
        o_res_valid         = 1'b0;
        case (state)
            IDLE, ERROR: begin
                if (i_start) state_next = ISSUE;
            end
            ISSUE: begin
                o_busy              = 1'b1;
                o_eng_start         = 1'b1;
                o_eng_kernel_reload = (out_idx == '0);
                state_next          = i_abort ? IDLE : WAIT;
            end
            WAIT: begin
                o_busy = 1'b1;
                if (i_abort)         state_next = IDLE;
                else if (i_eng_done) state_next = EMIT;
                else if (timed_out)  state_next = ERROR;
            end
            EMIT: begin
                o_busy      = 1'b1;
                o_res_valid = 1'b1;
                if (i_abort)          state_next = IDLE;
                else if (i_res_ready) state_next = last ? IDLE : ISSUE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wait_cnt   <= '0;
            o_err      <= 1'b0;
            o_done     <= 1'b0;
            o_res_data <= '0;
        end else begin
            o_done <= (state == EMIT) && i_res_ready && last && !i_abort;
            if (state != WAIT) begin
                wait_cnt <= '0;
            end else if (!timed_out) begin
                wait_cnt <= wait_cnt + TW'(1);
            end
            if (pos_clear) begin
                o_err <= 1'b0;
            end else if ((state == WAIT) && (state_next == ERROR)) begin
                o_err <= 1'b1;
            end
            if ((state == WAIT) && i_eng_done && !i_abort) begin
                o_res_data <= i_eng_result;
            end
        end
    end

endmodule
